// File: rtl/score_display_mux.sv
// N-digit BCD score counter with edge-triggered increment, sticky overflow,
// and a time-multiplexed active-low 7-segment driver with leading-zero blanking.
module score_display_mux #(
    parameter int DIGITS        = 4,
    parameter int STROBE_DIV    = 50000,
    parameter bit SATURATE      = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  INC,
    input  logic                  CLEAR,
    output logic [4*DIGITS-1:0]   SCORE_OUT,
    output logic                  OVERFLOW,
    output logic [DIGITS-1:0]     SEG_SELECT,
    output logic [7:0]            HEX_OUT
);

    localparam int PRE_W = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                 inc_q;
    logic                 inc_evt;
    logic [4*DIGITS-1:0]  score;
    logic [4*DIGITS-1:0]  inc_score;
    logic                 all_nines;
    logic                 overflow;
    logic [PRE_W-1:0]     presc;
    logic [IDX_W-1:0]     idx;
    logic [3:0]           cur_digit;
    logic                 upper_zero;
    logic                 blank;
    logic [DIGITS-1:0]    sel_n;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes go blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    assign inc_evt   = INC & ~inc_q;
    assign SCORE_OUT = score;
    assign OVERFLOW  = overflow;

    // Ripple BCD increment; a carry out of the top digit means the score was all 9s.
    always_comb begin
        logic carry;
        inc_score = score;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (score[4*i +: 4] == 4'd9) begin
                    inc_score[4*i +: 4] = 4'd0;
                end else begin
                    inc_score[4*i +: 4] = score[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    always_comb begin
        cur_digit  = 4'd0;
        upper_zero = 1'b1;
        sel_n      = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = score[4*i +: 4];
                sel_n[i]  = 1'b0;
            end
            if (IDX_W'(i) >= idx && score[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        blank = BLANK_LEADING && (idx != '0) && upper_zero;
    end

    // Stage 0: input edge register and score/overflow state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            inc_q    <= 1'b0;
            score    <= '0;
            overflow <= 1'b0;
        end else begin
            inc_q <= INC;
            if (CLEAR) begin
                score    <= '0;
                overflow <= 1'b0;
            end else if (inc_evt) begin
                if (all_nines) begin
                    overflow <= 1'b1;
                    if (!SATURATE) begin
                        score <= '0;
                    end
                end else begin
                    score <= inc_score;
                end
            end
        end
    end

    // Stage 0: digit strobe prescaler and slot index.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRE_W'(STROBE_DIV - 1)) begin
            presc <= '0;
            if (DIGITS > 1) begin
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Stage 1: registered anode select and segment drive.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEG_SELECT <= '1;
            HEX_OUT    <= 8'hFF;
        end else begin
            SEG_SELECT <= sel_n;
            if (blank) begin
                HEX_OUT <= 8'hFF;
            end else begin
                HEX_OUT <= {~((idx == '0) && overflow), seg_decode(cur_digit)};
            end
        end
    end

endmodule

// File: tb/tb_score_display_mux.sv
// Scoreboard bench: four parameter variants share INC/CLEAR/RESET; expectations are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_score_display_mux;

    logic CLK = 1'b0;
    logic RESET, INC, CLEAR;

    logic [15:0] score_a, score_d;
    logic [7:0]  score_b, score_c;
    logic        ovf_a, ovf_b, ovf_c, ovf_d;
    logic [3:0]  sel_a, sel_d;
    logic [1:0]  sel_b, sel_c;
    logic [7:0]  hex_a, hex_b, hex_c, hex_d;

    logic timed_out = 1'b0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        string       name;
        int          dut;
        int          fld;
        logic [15:0] val;
    } exp_t;
    exp_t q[$];

    always #5 CLK = ~CLK;

    score_display_mux #(.DIGITS(4), .STROBE_DIV(4), .SATURATE(1'b1), .BLANK_LEADING(1'b1)) dut_a (
        .CLK(CLK), .RESET(RESET), .INC(INC), .CLEAR(CLEAR),
        .SCORE_OUT(score_a), .OVERFLOW(ovf_a), .SEG_SELECT(sel_a), .HEX_OUT(hex_a));
    score_display_mux #(.DIGITS(2), .STROBE_DIV(4), .SATURATE(1'b1), .BLANK_LEADING(1'b1)) dut_b (
        .CLK(CLK), .RESET(RESET), .INC(INC), .CLEAR(CLEAR),
        .SCORE_OUT(score_b), .OVERFLOW(ovf_b), .SEG_SELECT(sel_b), .HEX_OUT(hex_b));
    score_display_mux #(.DIGITS(2), .STROBE_DIV(4), .SATURATE(1'b0), .BLANK_LEADING(1'b1)) dut_c (
        .CLK(CLK), .RESET(RESET), .INC(INC), .CLEAR(CLEAR),
        .SCORE_OUT(score_c), .OVERFLOW(ovf_c), .SEG_SELECT(sel_c), .HEX_OUT(hex_c));
    score_display_mux #(.DIGITS(4), .STROBE_DIV(4), .SATURATE(1'b1), .BLANK_LEADING(1'b0)) dut_d (
        .CLK(CLK), .RESET(RESET), .INC(INC), .CLEAR(CLEAR),
        .SCORE_OUT(score_d), .OVERFLOW(ovf_d), .SEG_SELECT(sel_d), .HEX_OUT(hex_d));

    // fld: 0=score 1=overflow 2=seg_select 3=hex 4=wait-timeout flag
    function automatic logic [15:0] actual(input int d, input int f);
        logic [15:0] sc, sg, hx;
        logic        ov;
        case (d)
            0:       begin sc = score_a;         ov = ovf_a; sg = {12'h0, sel_a}; hx = {8'h0, hex_a}; end
            1:       begin sc = {8'h0, score_b}; ov = ovf_b; sg = {14'h0, sel_b}; hx = {8'h0, hex_b}; end
            2:       begin sc = {8'h0, score_c}; ov = ovf_c; sg = {14'h0, sel_c}; hx = {8'h0, hex_c}; end
            default: begin sc = score_d;         ov = ovf_d; sg = {12'h0, sel_d}; hx = {8'h0, hex_d}; end
        endcase
        case (f)
            0:       actual = sc;
            1:       actual = {15'h0, ov};
            2:       actual = sg;
            3:       actual = hx;
            default: actual = {15'h0, timed_out};
        endcase
    endfunction

    task automatic expect_val(input string name, input int d, input int f, input logic [15:0] v);
        exp_t e;
        e.name = name;
        e.dut  = d;
        e.fld  = f;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Monitor: drain all queued expectations at the falling edge.
    always @(negedge CLK) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e   = q.pop_front();
            act = actual(e.dut, e.fld);
            total++;
            if (act !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(); INC = 1'b1;
            step(); INC = 1'b0;
        end
        step(); step();
    endtask

    task automatic pulse_clear();
        step(); CLEAR = 1'b1;
        step(); CLEAR = 1'b0;
        step();
    endtask

    // Bounded wait until the given DUT selects the given anode pattern.
    task automatic wait_sel(input string name, input int d, input logic [3:0] target);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            if (actual(d, 2) == {12'h0, target}) hit = 1'b1;
        end
        if (!hit) timed_out = 1'b1;
        check_now({name, "_hit"}, {15'h0, hit}, 16'h0001);
        expect_val({name, "_wait"}, d, 4, 16'h0);
    endtask

    initial begin
        RESET = 1'b1;
        INC   = 1'b0;
        CLEAR = 1'b0;
        step();
        check_now("rst_sel_now", {12'h0, sel_a}, 16'h000F);
        check_now("rst_hex_now", {8'h0, hex_a},  16'h00FF);
        expect_val("rst_score", 0, 0, 16'h0000);
        expect_val("rst_ovf",   0, 1, 16'h0000);
        expect_val("rst_sel",   0, 2, 16'h000F);
        expect_val("rst_hex",   0, 3, 16'h00FF);
        expect_val("rst_sel_b", 1, 2, 16'h0003);
        step(); RESET = 1'b0;

        // Strobe sequence after release: slot 0 first, then 1,2,3,0 every 4 cycles.
        step();
        expect_val("slot0_sel", 0, 2, 16'h000E);
        expect_val("slot0_hex", 0, 3, 16'h00C0);
        repeat (4) @(posedge CLK); #1;
        expect_val("slot1_sel",   0, 2, 16'h000D);
        expect_val("slot1_hex",   0, 3, 16'h00FF);
        expect_val("slot1_hex_d", 3, 3, 16'h00C0);
        repeat (4) @(posedge CLK); #1;
        expect_val("slot2_sel", 0, 2, 16'h000B);
        expect_val("slot2_hex", 0, 3, 16'h00FF);
        repeat (4) @(posedge CLK); #1;
        expect_val("slot3_sel", 0, 2, 16'h0007);
        expect_val("slot3_hex", 0, 3, 16'h00FF);
        repeat (4) @(posedge CLK); #1;
        expect_val("slot0b_sel", 0, 2, 16'h000E);
        expect_val("slot0b_hex", 0, 3, 16'h00C0);

        // Held INC counts once, then 9 separated pulses: 10 total.
        step(); INC = 1'b1;
        repeat (10) step();
        INC = 1'b0;
        pulses(9);
        expect_val("ten_score",   0, 0, 16'h0010);
        expect_val("ten_score_d", 3, 0, 16'h0010);
        expect_val("ten_ovf",     0, 1, 16'h0000);
        wait_sel("ten_d1", 0, 4'b1101);
        expect_val("ten_d1_hex", 0, 3, 16'h00F9);
        wait_sel("ten_d0", 0, 4'b1110);
        expect_val("ten_d0_hex", 0, 3, 16'h00C0);

        // 100 pulses on 2-digit variants: saturate vs wrap.
        pulse_clear();
        expect_val("clr_score", 0, 0, 16'h0000);
        pulses(100);
        expect_val("sat_score",  1, 0, 16'h0099);
        expect_val("sat_ovf",    1, 1, 16'h0001);
        expect_val("wrap_score", 2, 0, 16'h0000);
        expect_val("wrap_ovf",   2, 1, 16'h0001);
        expect_val("a_hundred",  0, 0, 16'h0100);
        expect_val("a_no_ovf",   0, 1, 16'h0000);
        wait_sel("sat_d0", 1, 4'b0010);
        expect_val("sat_d0_hex", 1, 3, 16'h0010);
        wait_sel("wrap_d1", 2, 4'b0001);
        expect_val("wrap_d1_hex", 2, 3, 16'h00FF);
        wait_sel("wrap_d0", 2, 4'b0010);
        expect_val("wrap_d0_hex", 2, 3, 16'h0040);
        pulse_clear();
        expect_val("wrap_ovf_clr", 2, 1, 16'h0000);
        expect_val("sat_ovf_clr",  1, 1, 16'h0000);
        expect_val("sat_score_clr", 1, 0, 16'h0000);

        // CLEAR wins over a simultaneous INC edge.
        pulses(5);
        expect_val("five_score", 0, 0, 16'h0005);
        step(); CLEAR = 1'b1; INC = 1'b1;
        step(); CLEAR = 1'b0;
        step(); step();
        expect_val("clr_inc_score", 0, 0, 16'h0000);
        INC = 1'b0;

        // Score 7: no blanking on variant D, blanking on variant A.
        pulses(7);
        expect_val("seven_score", 3, 0, 16'h0007);
        wait_sel("nb_d3", 3, 4'b0111);
        expect_val("nb_d3_hex", 3, 3, 16'h00C0);
        wait_sel("nb_d2", 3, 4'b1011);
        expect_val("nb_d2_hex", 3, 3, 16'h00C0);
        wait_sel("nb_d1", 3, 4'b1101);
        expect_val("nb_d1_hex", 3, 3, 16'h00C0);
        wait_sel("nb_d0", 3, 4'b1110);
        expect_val("nb_d0_hex", 3, 3, 16'h00F8);
        wait_sel("bl_d1", 0, 4'b1101);
        expect_val("bl_d1_hex", 0, 3, 16'h00FF);

        // Asynchronous reset in the middle of a slot.
        wait_sel("mid", 3, 4'b1011);
        step();
        RESET = 1'b1;
        #1;
        expect_val("async_sel",   3, 2, 16'h000F);
        expect_val("async_hex",   3, 3, 16'h00FF);
        expect_val("async_score", 3, 0, 16'h0000);
        expect_val("async_sel_a", 0, 2, 16'h000F);
        step(); step();
        RESET = 1'b0;
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_display_mux.md
Name: score_display_mux

Overview:
- Parametrised successor to the single-digit score path: an N-digit BCD score counter plus a time-multiplexed 7-segment driver.
- Replaces the fixed single-digit score-counter and decoder pair at the game top level. The digit-select input is no longer tied off; the block strobes all digits itself.
- Score increments on target-reached events. It supports saturate or wrap at the maximum, leading-zero blanking, and a sticky overflow flag shown on the digit-0 dot.

Parameters:
- DIGITS, 4, number of BCD digits and anodes driven (1..4).
- STROBE_DIV, 50000, CLK cycles per digit slot (>=2).
- SATURATE, 1, 1 = hold at all-9s on increment, 0 = wrap to 0.
- BLANK_LEADING, 1, 1 = blank zero digits above the most significant non-zero digit.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- INC  in  1  increment request, level. Rising edge counts once.
- CLEAR  in  1  synchronous score clear (game restart).
- SCORE_OUT  out  4*DIGITS  BCD score, digit 0 in bits [3:0].
- OVERFLOW  out  1  sticky: an increment arrived at the maximum score.
- SEG_SELECT  out  DIGITS  active-low one-hot anode select.
- HEX_OUT  out  8  active-low segments, {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, RESET=1):
  - Score is 0; INC edge register is 0; OVERFLOW is 0.
  - Prescaler is 0; digit index is 0.
  - SEG_SELECT is all 1s; HEX_OUT is 8'hFF (all segments off).
- INC edge detect:
  - inc_evt = INC & ~INC_q, where INC_q is INC registered.
  - INC held high counts exactly once. Back-to-back pulses separated by one low cycle each count.
- Score update (registered; SCORE_OUT valid the cycle after inc_evt):
  - CLEAR has priority. Score goes to 0 and OVERFLOW goes to 0; an inc_evt in the same cycle is discarded.
  - On inc_evt, BCD ripple increment: digit 0 +1; a digit at 9 becomes 0 and carries into the next digit.
  - At all-9s with SATURATE=1: score holds and OVERFLOW is set.
  - At all-9s with SATURATE=0: score becomes 0 and OVERFLOW is set.
  - OVERFLOW clears only on CLEAR or RESET.
- Strobe:
  - Prescaler counts 0..STROBE_DIV-1 and wraps.
  - At terminal count the digit index advances, wrapping from DIGITS-1 to 0.
  - With DIGITS=1 the index is fixed at 0.
- Display output (registered, one cycle after index or score change):
  - SEG_SELECT = ~(1 << index).
  - HEX_OUT[6:0] is the decoded digit[index], active low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (values include dp=1). Codes A-F never occur; decode them to blank.
  - HEX_OUT[7] (dp) is 0 only when index==0 and OVERFLOW=1; otherwise 1.
- Blanking:
  - Applies when BLANK_LEADING=1 and index>0 and digit[index] and all higher digits are 0.
  - A blanked digit drives HEX_OUT=8'hFF while its SEG_SELECT bit is still driven low.
  - Digit 0 is never blanked.
- Reset mid-strobe: the index returns to 0 and the outputs go blank immediately (async).
- Concurrency: score updates and the strobe are independent. A digit change mid-slot appears on HEX_OUT the next cycle.

Test Plan (DIGITS=4, STROBE_DIV=4 unless stated):
- Reset release, no INC -> the cycle after release gives SEG_SELECT=4'b1110 and HEX_OUT=8'hC0. After 4 cycles SEG_SELECT=4'b1101 and HEX_OUT=8'hFF (blanked); the index cycles 0,1,2,3,0 every 4 cycles.
- Hold INC high 10 cycles, then 9 more single-cycle pulses separated by one low cycle -> SCORE_OUT=16'h0010. Digit 1 shows 8'hF9 and digit 0 shows 8'hC0.
- SATURATE=1, DIGITS=2, 100 INC pulses -> SCORE_OUT=8'h99 and OVERFLOW=1. The digit-0 slot shows HEX_OUT=8'h10 (9 with dp on).
- SATURATE=0, DIGITS=2, 100 INC pulses -> SCORE_OUT=8'h00 and OVERFLOW=1. Pulse CLEAR -> OVERFLOW=0.
- CLEAR and an INC rising edge in the same cycle at score 0x0005 -> SCORE_OUT=0; the increment is not applied.
- BLANK_LEADING=0 at score 0x0007 -> all four slots lit: C0, C0, C0, F8 for digits 3..0. Assert RESET mid-slot -> SEG_SELECT=4'hF and HEX_OUT=8'hFF the same cycle.
